als_sample_sequencer: RTL and testbench

- Sequences periodic and on-demand reads of the PmodALS light sensor (ADC081S021, 16-bit frame) through the existing SPI master.
- Owns chip-select timing, start/done handshake, timeout supervision, frame validation and extraction of the 8-bit light value for the display path.
- Sits between the top-level control inputs and the SPI master; the SPI master only shifts bits and drives SCK.

---
 rtl/als_seq_pkg.sv | 25 ++
 rtl/als_tick_gen.sv | 32 +++
 rtl/als_sample_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_als_sample_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/als_seq_pkg.sv
// Shared types and frame-format constants for the PmodALS sample sequencer.
package als_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStart,
    StWait,
    StHold,
    StUpdate
  } state_e;

  localparam int unsigned ALS_FRAME_W  = 16;
  localparam int unsigned ALS_DATA_MSB = 11;
  localparam int unsigned ALS_DATA_LSB = 4;

  localparam logic [ALS_FRAME_W-1:0] ALS_LEAD_MASK  = 16'hF000;
  localparam logic [ALS_FRAME_W-1:0] ALS_TRAIL_MASK = 16'h000F;

  // ADC081S021 frames carry four leading and four trailing zeros around the data byte.
  function automatic logic frame_ok(input logic [ALS_FRAME_W-1:0] rx);
    return (rx & (ALS_LEAD_MASK | ALS_TRAIL_MASK)) == '0;
  endfunction

endpackage

// File: rtl/als_tick_gen.sv
// Free-running period counter: one-cycle tick every PERIOD_CYC cycles while enabled.
module als_tick_gen #(
  parameter int unsigned PERIOD_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PERIOD_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == CntLast);
    cnt_d = cnt_q + CntW'(1);
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/als_sample_sequencer.sv
// Sequences PmodALS reads through the SPI master: CS timing, timeout, frame check.
// Define ALS_AVG_EN to publish the mean of every four valid samples instead of each one.
module als_sample_sequencer
  import als_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_PERIOD_CYC = 1_000_000,
  parameter int unsigned CS_SETUP_CYC      = 2,
  parameter int unsigned CS_HOLD_CYC       = 2,
  parameter int unsigned TIMEOUT_CYC       = 64
) (
  input  logic                   clk_pi,
  input  logic                   rst_pi,
  input  logic                   en_pi,
  input  logic                   trig_pi,
  input  logic                   err_clr_pi,
  input  logic                   spi_busy_pi,
  input  logic                   spi_done_pi,
  input  logic [ALS_FRAME_W-1:0] spi_rx_pi,
  output logic                   spi_start_po,
  output logic                   cs_ctrl_po,
  output logic [7:0]             sample_po,
  output logic                   sample_valid_po,
  output logic                   busy_po,
  output logic                   frame_err_po,
  output logic                   timeout_err_po
);

  localparam int unsigned CntMax0 = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int unsigned CntMax  = (CntMax0 > TIMEOUT_CYC) ? CntMax0 : TIMEOUT_CYC;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SetupLast = CntW'(CS_SETUP_CYC - 1);
  localparam logic [CntW-1:0] HoldLast  = CntW'(CS_HOLD_CYC - 1);
  localparam logic [CntW-1:0] TmoLast   = CntW'(TIMEOUT_CYC - 1);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   pending_q, pending_d;
  logic                   got_q, got_d;
  logic [ALS_FRAME_W-1:0] rx_q, rx_d;
  logic [7:0]             sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d, terr_q, terr_d;
  logic                   tick, launch, accept, ferr_set, terr_set;
  logic [7:0]             rx_data;

  als_tick_gen #(
    .PERIOD_CYC(SAMPLE_PERIOD_CYC)
  ) u_tick (
    .clk (clk_pi),
    .rst (rst_pi),
    .en  (en_pi),
    .tick(tick)
  );

  assign rx_data = rx_q[ALS_DATA_MSB:ALS_DATA_LSB];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    got_d        = got_q;
    rx_d         = rx_q;
    launch       = 1'b0;
    accept       = 1'b0;
    ferr_set     = 1'b0;
    terr_set     = 1'b0;
    cs_ctrl_po   = 1'b0;
    spi_start_po = 1'b0;
    unique case (state_q)
      StIdle: begin
        cs_ctrl_po = 1'b1;
        if (pending_q && !spi_busy_pi) begin
          launch  = 1'b1;
          cnt_d   = '0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == SetupLast) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        spi_start_po = 1'b1;
        got_d        = 1'b0;
        cnt_d        = '0;
        state_d      = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (spi_done_pi) begin
          rx_d    = spi_rx_pi;
          got_d   = 1'b1;
          cnt_d   = '0;
          state_d = StHold;
        end else if (cnt_q == TmoLast) begin
          terr_set = 1'b1;
          got_d    = 1'b0;
          cnt_d    = '0;
          state_d  = StHold;
        end
      end
      StHold: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        cs_ctrl_po = 1'b1;
        state_d    = StIdle;
        if (got_q) begin
          accept   = frame_ok(rx_q);
          ferr_set = !frame_ok(rx_q);
        end
      end
      default: begin
        cs_ctrl_po = 1'b1;
        state_d    = StIdle;
      end
    endcase
  end

  // New requests win over the launch clear so nothing arriving that cycle is lost.
  assign pending_d = tick | trig_pi | (pending_q & ~launch);
  assign ferr_d    = ferr_set | (ferr_q & ~err_clr_pi);
  assign terr_d    = terr_set | (terr_q & ~err_clr_pi);

`ifdef ALS_AVG_EN
  logic [9:0] sum_q, sum_d, sum_nx;
  logic [1:0] avg_n_q, avg_n_d;

  always_comb begin
    sample_d = sample_q;
    valid_d  = 1'b0;
    sum_d    = sum_q;
    avg_n_d  = avg_n_q;
    sum_nx   = sum_q + {2'b00, rx_data};
    if (accept) begin
      if (avg_n_q == 2'd3) begin
        sample_d = sum_nx[9:2];
        valid_d  = 1'b1;
        sum_d    = '0;
        avg_n_d  = '0;
      end else begin
        sum_d   = sum_nx;
        avg_n_d = avg_n_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      sum_q   <= '0;
      avg_n_q <= '0;
    end else begin
      sum_q   <= sum_d;
      avg_n_q <= avg_n_d;
    end
  end
`else
  always_comb begin
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (accept) begin
      sample_d = rx_data;
      valid_d  = 1'b1;
    end
  end
`endif

  always_ff @(posedge clk_pi or posedge rst_pi) begin
    if (rst_pi) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      got_q     <= 1'b0;
      rx_q      <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      got_q     <= got_d;
      rx_q      <= rx_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      terr_q    <= terr_d;
    end
  end

  assign sample_po       = sample_q;
  assign sample_valid_po = valid_q;
  assign busy_po         = (state_q != StIdle);
  assign frame_err_po    = ferr_q;
  assign timeout_err_po  = terr_q;

endmodule

// File: tb/tb_als_sample_sequencer.sv
// Self-checking bench for als_sample_sequencer with an SPI responder and a behavioural model.
module tb_als_sample_sequencer;

  localparam int unsigned PERIOD   = 100;
  localparam int unsigned SETUP    = 2;
  localparam int unsigned HOLD     = 2;
  localparam int unsigned TMO      = 16;
  localparam int          DONE_LAT = 10;

  logic        clk = 1'b0;
  logic        rst, en, trig, err_clr, spi_done;
  logic        mdl_busy, hold_busy, spi_busy;
  logic [15:0] spi_rx;
  logic        spi_start, cs_ctrl, sample_valid, busy, frame_err, timeout_err;
  logic [7:0]  sample;

  assign spi_busy = mdl_busy | hold_busy;

  als_sample_sequencer #(
    .SAMPLE_PERIOD_CYC(PERIOD),
    .CS_SETUP_CYC     (SETUP),
    .CS_HOLD_CYC      (HOLD),
    .TIMEOUT_CYC      (TMO)
  ) dut (
    .clk_pi         (clk),
    .rst_pi         (rst),
    .en_pi          (en),
    .trig_pi        (trig),
    .err_clr_pi     (err_clr),
    .spi_busy_pi    (spi_busy),
    .spi_done_pi    (spi_done),
    .spi_rx_pi      (spi_rx),
    .spi_start_po   (spi_start),
    .cs_ctrl_po     (cs_ctrl),
    .sample_po      (sample),
    .sample_valid_po(sample_valid),
    .busy_po        (busy),
    .frame_err_po   (frame_err),
    .timeout_err_po (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SPI responder: answers DONE_LAT cycles after a start pulse unless muted.
  logic [15:0] spi_frame = '0;
  bit          spi_mute  = 1'b0;
  int          spi_cnt;
  initial begin
    spi_done = 1'b0;
    spi_rx   = '0;
    mdl_busy = 1'b0;
    spi_cnt  = 0;
    forever begin
      step();
      spi_done = 1'b0;
      if (rst) begin
        spi_cnt  = 0;
        mdl_busy = 1'b0;
      end else if (spi_cnt > 0) begin
        spi_cnt--;
        if (spi_cnt == 0) begin
          mdl_busy = 1'b0;
          if (!spi_mute) begin
            spi_done = 1'b1;
            spi_rx   = spi_frame;
          end
        end
      end else if (spi_start) begin
        spi_cnt  = DONE_LAT;
        mdl_busy = 1'b1;
      end
    end
  end

  int cyc  = 0;
  int vcnt = 0;
  int start_q[$];
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (sample_valid) vcnt++;
      if (spi_start) start_q.push_back(cyc);
    end
  end

  // Behavioural reference: what the published sample and flags should be after each frame.
  logic [7:0] m_sample;
  bit         m_ferr, m_terr;
  int         m_pulses, m_sum, m_n, vbase;

  task automatic model_txn(input logic [15:0] rx, input bit got);
    int lead, trail, data;
    lead  = int'(rx) / 4096;
    trail = int'(rx) % 16;
    data  = (int'(rx) / 16) % 256;
    if (!got) begin
      m_terr = 1'b1;
    end else if (lead == 0 && trail == 0) begin
`ifdef ALS_AVG_EN
      m_sum += data;
      m_n++;
      if (m_n == 4) begin
        m_sample = 8'(m_sum / 4);
        m_pulses++;
        m_sum = 0;
        m_n   = 0;
      end
`else
      m_sample = 8'(data);
      m_pulses++;
`endif
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".sample"}, sample, m_sample);
    check({tag, ".pulses"}, vcnt - vbase, m_pulses);
    check({tag, ".frame_err"}, frame_err, m_ferr);
    check({tag, ".timeout_err"}, timeout_err, m_terr);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    trig    = 1'b0;
    en      = 1'b0;
    err_clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    m_sample = '0;
    m_ferr   = 1'b0;
    m_terr   = 1'b0;
    m_pulses = 0;
    m_sum    = 0;
    m_n      = 0;
    vbase    = vcnt;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    m_ferr  = 1'b0;
    m_terr  = 1'b0;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (!busy && n < maxc) begin step(); n++; end
    while (busy && n < maxc) begin step(); n++; end
    check("wait_done.bound", n < maxc, 1);
    step();
    step();
  endtask

  task automatic run_txn(input logic [15:0] rx, input bit mute);
    spi_frame = rx;
    spi_mute  = mute;
    pulse_trig();
    wait_done(80);
    model_txn(rx, !mute);
  endtask

  // Cycle-exact walk through one transaction; read n is 1 ns after the n-th edge past trig.
  task automatic timed_txn(input logic [15:0] rx, input bit mute);
    int p0, s, h;
    bit pulse;
    p0 = m_pulses;
    model_txn(rx, !mute);
    pulse = (m_pulses != p0);
    s = SETUP + 1;
    h = mute ? s + 1 + int'(TMO) : s + 1 + DONE_LAT;
    spi_frame = rx;
    spi_mute  = mute;
    pulse_trig();
    for (int n = 0; n <= h + 4; n++) begin
      if (n > 0) step();
      check($sformatf("t%0d.cs", n), cs_ctrl, !(n >= 1 && n <= h + 1));
      check($sformatf("t%0d.start", n), spi_start, n == s);
      check($sformatf("t%0d.busy", n), busy, n >= 1 && n <= h + 2);
      check($sformatf("t%0d.valid", n), sample_valid, pulse && n == h + 3);
      if (mute) check($sformatf("t%0d.timeout_err", n), timeout_err, n >= h);
    end
  endtask

  typedef struct {
    logic [15:0] rx;
    logic [7:0]  exp_sample;
    logic        exp_pulse;
    logic        exp_ferr;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] rx, input logic [7:0] s, input logic p,
                              input logic f);
    vec_t v;
    v.rx         = rx;
    v.exp_sample = s;
    v.exp_pulse  = p;
    v.exp_ferr   = f;
    return v;
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t        tbl[$];
    int          v0;
    logic [15:0] rx;
    bit          mute;

    hold_busy = 1'b0;
    do_reset();
    check("reset.cs", cs_ctrl, 1);
    check("reset.start", spi_start, 0);
    check("reset.sample", sample, 0);
    check("reset.valid", sample_valid, 0);
    check("reset.busy", busy, 0);
    check("reset.frame_err", frame_err, 0);
    check("reset.timeout_err", timeout_err, 0);

    timed_txn(16'h0AB0, 1'b0);
    check_model("good");
    timed_txn(16'h8AB1, 1'b0);
    check_model("bad");
    clear_errs();
    check("bad.cleared", frame_err, 0);

    timed_txn(16'h0CD0, 1'b1);
    check_model("timeout");
    clear_errs();
    check("timeout.cleared", timeout_err, 0);
    run_txn(16'h0CD0, 1'b0);
    check_model("after_timeout");

    // A busy SPI master holds off the launch until it goes idle.
    start_q.delete();
    hold_busy = 1'b1;
    spi_frame = 16'h0120;
    spi_mute  = 1'b0;
    pulse_trig();
    repeat (10) step();
    check("busy_hold.starts", start_q.size(), 0);
    check("busy_hold.cs", cs_ctrl, 1);
    hold_busy = 1'b0;
    wait_done(60);
    model_txn(16'h0120, 1'b1);
    check_model("busy_release");
    check("busy_release.starts", start_q.size(), 1);

    start_q.delete();
    spi_frame = 16'h0AB0;
    en = 1'b1;
    repeat (350) step();
    en = 1'b0;
    repeat (40) step();
    check("period.count", start_q.size(), 3);
    for (int i = 1; i < start_q.size(); i++) begin
      check($sformatf("period.gap%0d", i), start_q[i] - start_q[i-1], PERIOD);
    end

    for (int k = 1; k <= 3; k += 2) begin
      start_q.delete();
      pulse_trig();
      repeat (7) step();
      for (int j = 0; j < k; j++) begin
        check($sformatf("collapse%0d.in_wait%0d", k, j), busy && !cs_ctrl && !spi_start, 1);
        pulse_trig();
        step();
      end
      repeat (60) step();
      check($sformatf("collapse%0d.starts", k), start_q.size(), 2);
    end

    do_reset();
`ifdef ALS_AVG_EN
    tbl.push_back(mk(16'h0100, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0200, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(16'h0300, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(16'h8AB1, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(16'h0410, 8'h28, 1'b1, 1'b0));
`else
    tbl.push_back(mk(16'h0AB0, 8'hAB, 1'b1, 1'b0));
    tbl.push_back(mk(16'h8AB1, 8'hAB, 1'b0, 1'b1));
    tbl.push_back(mk(16'h0FF0, 8'hFF, 1'b1, 1'b0));
    tbl.push_back(mk(16'h0000, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(16'h0125, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(16'h1340, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(16'h0340, 8'h34, 1'b1, 1'b0));
`endif
    foreach (tbl[i]) begin
      v0 = vcnt;
      run_txn(tbl[i].rx, 1'b0);
      check($sformatf("tbl%0d.sample", i), sample, tbl[i].exp_sample);
      check($sformatf("tbl%0d.pulse", i), vcnt - v0, tbl[i].exp_pulse);
      check($sformatf("tbl%0d.frame_err", i), frame_err, tbl[i].exp_ferr);
      clear_errs();
    end

    do_reset();
    repeat (24) begin
      if ($urandom_range(0, 1) == 1) rx = {4'h0, 8'($urandom), 4'h0};
      else rx = 16'($urandom);
      mute = ($urandom_range(0, 7) == 0);
      run_txn(rx, mute);
      check_model($sformatf("rand_%04h", rx));
      if ($urandom_range(0, 2) == 0) begin
        clear_errs();
        check_model("rand_clr");
      end
    end

    // Asynchronous reset in the middle of a transaction.
    run_txn(16'h0AB0, 1'b0);
    run_txn(16'h8AB1, 1'b0);
    spi_frame = 16'h0CD0;
    spi_mute  = 1'b0;
    pulse_trig();
    repeat (8) step();
    check("pre_rst.busy", busy, 1);
    check("pre_rst.frame_err", frame_err, 1);
    #2 rst = 1'b1;
    #1;
    check("rst.cs", cs_ctrl, 1);
    check("rst.start", spi_start, 0);
    check("rst.sample", sample, 0);
    check("rst.valid", sample_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.frame_err", frame_err, 0);
    check("rst.timeout_err", timeout_err, 0);
    step();
    step();
    rst = 1'b0;
    v0 = vcnt;
    repeat (30) step();
    check("rst.discard_pulses", vcnt - v0, 0);
    check("rst.discard_sample", sample, 0);
    check("rst.idle_cs", cs_ctrl, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
